// File: rtl/param_mux_sched_if.sv
// Channel-side and consumer-side handshake bundle for param_mux_sched.
// The producer/consumer environment takes master; the mux takes slave.
interface param_mux_sched_if #(
   parameter int WIDTH = 8,
   parameter int NCH   = 4,
   parameter int SELW  = 2
);
   logic [NCH*WIDTH-1:0] in_data;
   logic [NCH-1:0]       in_valid;
   logic [NCH-1:0]       in_ready;
   logic                 mode;
   logic [SELW-1:0]      sel;
   logic [WIDTH-1:0]     out_data;
   logic [SELW-1:0]      out_ch;
   logic                 out_valid;
   logic                 out_ready;

   modport master (
      output in_data, in_valid, mode, sel, out_ready,
      input  in_ready, out_data, out_ch, out_valid
   );

   modport slave (
      input  in_data, in_valid, mode, sel, out_ready,
      output in_ready, out_data, out_ch, out_valid
   );
endinterface

// File: rtl/param_mux_sched.sv
// NCH-to-1 valid/ready channel merge with manual or round-robin selection
// and a single registered output word.
module param_mux_sched #(
   parameter int WIDTH = 8,
   parameter int NCH   = 4,
   parameter int SELW  = 2
) (
   input logic              clk,
   input logic              rst,
   param_mux_sched_if.slave bus
);
   // state   | meaning
   // S_EMPTY | output register holds no word
   // S_FULL  | out_data/out_ch hold a word waiting for out_ready
   typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [SELW-1:0]  out_ch_q, out_ch_d;
   logic [SELW-1:0]  ptr_q, ptr_d;
   logic [SELW-1:0]  chosen;
   logic             grant;
   logic             load_en;
   logic             xfer;

   always_comb begin
      int idx;
      idx    = 0;
      grant  = 1'b0;
      chosen = '0;
      if (!bus.mode) begin
         if (int'(bus.sel) < NCH) begin
            grant  = bus.in_valid[bus.sel];
            chosen = bus.sel;
         end
      end else begin
         // scan ptr..NCH-1 then 0..ptr-1; wrap is an explicit compare so odd NCH works
         for (int j = 0; j < NCH; j++) begin
            idx = int'(ptr_q) + j;
            if (idx >= NCH) idx = idx - NCH;
            if (!grant && bus.in_valid[idx]) begin
               grant  = 1'b1;
               chosen = SELW'(idx);
            end
         end
      end
   end

   assign load_en = (state_q == S_EMPTY) || bus.out_ready;
   assign xfer    = grant && load_en && !rst;

   always_comb begin
      bus.in_ready = '0;
      if (xfer) bus.in_ready[chosen] = 1'b1;
   end

   always_comb begin
      state_d    = state_q;
      out_data_d = out_data_q;
      out_ch_d   = out_ch_q;
      ptr_d      = ptr_q;
      if (xfer) begin
         state_d    = S_FULL;
         out_data_d = bus.in_data[int'(chosen)*WIDTH +: WIDTH];
         out_ch_d   = chosen;
         if (bus.mode) ptr_d = (chosen == SELW'(NCH-1)) ? '0 : chosen + 1'b1;
      end else if (state_q == S_FULL && bus.out_ready) begin
         state_d = S_EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_EMPTY;
         out_data_q <= '0;
         out_ch_q   <= '0;
         ptr_q      <= '0;
      end else begin
         state_q    <= state_d;
         out_data_q <= out_data_d;
         out_ch_q   <= out_ch_d;
         ptr_q      <= ptr_d;
      end
   end

   assign bus.out_valid = (state_q == S_FULL);
   assign bus.out_data  = out_data_q;
   assign bus.out_ch    = out_ch_q;
endmodule

// File: tb/tb_param_mux_sched.sv
// Bench for param_mux_sched: directed table, hand sequences (NCH=4 and NCH=3)
// and randomized traffic against a queue-based reference model.
module tb_param_mux_sched;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst4, rst3;

   param_mux_sched_if #(.WIDTH(8), .NCH(4), .SELW(2)) i4();
   param_mux_sched_if #(.WIDTH(8), .NCH(3), .SELW(2)) i3();

   param_mux_sched #(.WIDTH(8), .NCH(4), .SELW(2)) u4 (.clk(clk), .rst(rst4), .bus(i4.slave));
   param_mux_sched #(.WIDTH(8), .NCH(3), .SELW(2)) u3 (.clk(clk), .rst(rst3), .bus(i3.slave));

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic       rst;
      logic       mode;
      logic [1:0] sel;
      logic [3:0] iv;
      logic       ordy;
      logic [3:0] exp_rdy;
      logic       exp_ov;
      logic [1:0] exp_ch;
      logic [7:0] exp_dat;
   } vec_t;

   vec_t tbl[16];

   // reference model state
   bit         m_ov;
   logic [7:0] m_dat;
   int         m_ch;
   int         m_ptr;

   function automatic int rr_pick(input logic [3:0] v, input int p, input int n);
      int order[$];
      for (int i = 0; i < n; i++) order.push_back((p + i) % n);
      foreach (order[i]) if (v[order[i]]) return order[i];
      return -1;
   endfunction

   initial begin
      // channel data: ch3=D3 ch2=A5 ch1=B1 ch0=3C
      //               rst  mode sel   iv    ordy  rdy   ov    ch    dat
      tbl[0]  = '{1'b1, 1'b1, 2'd0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 8'h00};
      tbl[1]  = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 8'h3C};
      tbl[2]  = '{1'b0, 1'b0, 2'd2, 4'h4, 1'b1, 4'h4, 1'b1, 2'd2, 8'hA5};
      tbl[3]  = '{1'b0, 1'b0, 2'd3, 4'h4, 1'b1, 4'h0, 1'b0, 2'd2, 8'hA5};
      tbl[4]  = '{1'b0, 1'b1, 2'd0, 4'h9, 1'b1, 4'h8, 1'b1, 2'd3, 8'hD3};
      tbl[5]  = '{1'b0, 1'b1, 2'd0, 4'h9, 1'b1, 4'h1, 1'b1, 2'd0, 8'h3C};
      tbl[6]  = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd0, 8'h3C};
      tbl[7]  = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd0, 8'h3C};
      tbl[8]  = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd0, 8'h3C};
      tbl[9]  = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 8'hB1};
      tbl[10] = '{1'b0, 1'b0, 2'd3, 4'h0, 1'b0, 4'h0, 1'b1, 2'd1, 8'hB1};
      tbl[11] = '{1'b0, 1'b1, 2'd0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd1, 8'hB1};
      tbl[12] = '{1'b0, 1'b0, 2'd1, 4'h2, 1'b0, 4'h2, 1'b1, 2'd1, 8'hB1};
      tbl[13] = '{1'b0, 1'b1, 2'd0, 4'h3, 1'b1, 4'h1, 1'b1, 2'd0, 8'h3C};
      tbl[14] = '{1'b1, 1'b1, 2'd0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 8'h00};
      tbl[15] = '{1'b0, 1'b1, 2'd0, 4'h6, 1'b1, 4'h2, 1'b1, 2'd1, 8'hB1};

      rst4 = 1'b1;
      rst3 = 1'b1;
      i4.mode = 1'b0; i4.sel = 2'd0; i4.in_valid = 4'h0; i4.out_ready = 1'b0; i4.in_data = 32'h0;
      i3.mode = 1'b0; i3.sel = 2'd0; i3.in_valid = 3'h0; i3.out_ready = 1'b0; i3.in_data = 24'h0;
      @(posedge clk); #1;

      // ---------------- table-driven directed vectors ----------------
      for (int t = 0; t < 16; t++) begin
         rst4         = tbl[t].rst;
         i4.mode      = tbl[t].mode;
         i4.sel       = tbl[t].sel;
         i4.in_valid  = tbl[t].iv;
         i4.out_ready = tbl[t].ordy;
         i4.in_data   = 32'hD3A5_B13C;
         #3;
         chk($sformatf("tbl%0d_in_ready", t), 32'(i4.in_ready), 32'(tbl[t].exp_rdy));
         @(posedge clk); #1;
         chk($sformatf("tbl%0d_out_valid", t), 32'(i4.out_valid), 32'(tbl[t].exp_ov));
         chk($sformatf("tbl%0d_out_ch", t),    32'(i4.out_ch),    32'(tbl[t].exp_ch));
         chk($sformatf("tbl%0d_out_data", t),  32'(i4.out_data),  32'(tbl[t].exp_dat));
      end

      // ---------------- NCH=4 round-robin full throughput ----------------
      rst4 = 1'b1; i4.mode = 1'b1; i4.in_valid = 4'hF; i4.out_ready = 1'b1;
      @(posedge clk); #1;
      rst4 = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         chk($sformatf("rr4_ch%0d", i), 32'(i4.out_ch), 32'(i % 4));
         chk($sformatf("rr4_ov%0d", i), 32'(i4.out_valid), 32'd1);
      end

      // ---------------- NCH=3 build: wrap at 2, reset mid-stream ----------------
      i3.mode = 1'b1; i3.in_valid = 3'b111; i3.out_ready = 1'b1; i3.in_data = 24'hC2B1A0;
      rst3 = 1'b1;
      #2;
      chk("rr3_ready_in_rst", 32'(i3.in_ready), 32'h0);
      @(posedge clk); #1;
      chk("rr3_ov_after_rst", 32'(i3.out_valid), 32'd0);
      rst3 = 1'b0;
      #1;
      chk("rr3_first_ready", 32'(i3.in_ready), 32'h1);
      for (int i = 0; i < 4; i++) begin
         logic [23:0] d;
         d = 24'hC2B1A0;
         @(posedge clk); #1;
         chk($sformatf("rr3_ch%0d", i), 32'(i3.out_ch), 32'(i % 3));
         chk($sformatf("rr3_dat%0d", i), 32'(i3.out_data), 32'(d[(i % 3)*8 +: 8]));
      end
      rst3 = 1'b1;
      @(posedge clk); #1;
      chk("rr3_midrst_ov", 32'(i3.out_valid), 32'd0);
      chk("rr3_midrst_ready", 32'(i3.in_ready), 32'h0);
      rst3 = 1'b0;
      @(posedge clk); #1;
      chk("rr3_post_rst_ch", 32'(i3.out_ch), 32'd0);
      chk("rr3_post_rst_dat", 32'(i3.out_data), 32'hA0);
      rst3 = 1'b1;

      // ---------------- randomized traffic vs reference model ----------------
      rst4 = 1'b1;
      @(posedge clk); #1;
      m_ov = 1'b0; m_dat = 8'h00; m_ch = 0; m_ptr = 0;
      for (int c = 0; c < 3000; c++) begin
         logic       r;
         int         k;
         bit         le;
         logic [3:0] exp_rdy;
         r            = ($urandom_range(0, 63) == 0);
         rst4         = r;
         i4.mode      = 1'($urandom_range(0, 1));
         i4.sel       = 2'($urandom_range(0, 3));
         i4.in_valid  = 4'($urandom_range(0, 15));
         i4.out_ready = ($urandom_range(0, 3) != 0);
         i4.in_data   = $urandom;
         #3;
         if (i4.mode) k = rr_pick(i4.in_valid, m_ptr, 4);
         else         k = i4.in_valid[i4.sel] ? int'(i4.sel) : -1;
         le      = !m_ov || i4.out_ready;
         exp_rdy = (!r && k >= 0 && le) ? 4'(1 << k) : 4'h0;
         chk("rnd_in_ready",  32'(i4.in_ready),  32'(exp_rdy));
         chk("rnd_out_valid", 32'(i4.out_valid), 32'(m_ov));
         chk("rnd_out_ch",    32'(i4.out_ch),    32'(m_ch));
         chk("rnd_out_data",  32'(i4.out_data),  32'(m_dat));
         if (r) begin
            m_ov = 1'b0; m_dat = 8'h00; m_ch = 0; m_ptr = 0;
         end else if (k >= 0 && le) begin
            m_ov  = 1'b1;
            m_dat = i4.in_data[k*8 +: 8];
            m_ch  = k;
            if (i4.mode) m_ptr = (k + 1) % 4;
         end else if (m_ov && i4.out_ready) begin
            m_ov = 1'b0;
         end
         @(posedge clk); #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/param_mux_sched.md
Name: param_mux_sched

Overview:
- Parametrised NCH-to-1 multiplexer with WIDTH-bit data channels and a registered output stage.
- Each input channel and the output use valid/ready handshakes.
- Two selection modes: manual (an external select chooses the channel) and round-robin (an internal pointer scans the channels fairly).
- Used as the channel-merge stage wherever several producer streams share one consumer.

Parameters:
- WIDTH, 8, data bits per channel.
- NCH, 4, number of input channels (2..16).
- SELW, 2, select/pointer width; must equal ceil(log2(NCH)).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_data  input  NCH*WIDTH  channel i data on bits [i*WIDTH +: WIDTH].
- in_valid  input  NCH  per-channel valid.
- in_ready  output  NCH  per-channel ready; combinational.
- mode  input  1  0 = manual, 1 = round-robin.
- sel  input  SELW  manual channel select; sampled every cycle.
- out_data  output  WIDTH  registered data.
- out_ch  output  SELW  index of the channel that supplied out_data.
- out_valid  output  1  output holds a word.
- out_ready  input  1  consumer accepts the word.

Behaviour:
- Reset: out_valid=0, out_data=0, out_ch=0, ptr=0. in_ready is all-zero while rst=1.
- Output register has two implicit states, EMPTY (out_valid=0) and FULL (out_valid=1).
- load_en = !out_valid | out_ready.
- Channel choice, manual mode: the chosen channel is sel.
  - A grant occurs only if sel < NCH and in_valid[sel]=1.
  - sel >= NCH grants nothing.
- Channel choice, round-robin mode: the chosen channel is the first i with in_valid[i]=1, scanning ptr, ptr+1, …, NCH-1, 0, …, ptr-1.
  - No grant if no channel is valid.
- in_ready[i] = load_en & grant & (chosen==i). At most one bit is set.
- A transfer on channel k occurs when in_valid[k] & in_ready[k].
  - Next edge: out_data <= channel k data, out_ch <= k, out_valid <= 1.
- If the output is consumed (out_valid & out_ready) and no grant occurs, out_valid <= 0. out_data and out_ch hold their old values.
- Stall: while out_valid & !out_ready, out_data and out_ch stay stable and in_ready is all-zero.
- Latency: 1 cycle from input transfer to out_valid. Full throughput of 1 word/cycle with out_ready held high.
- Pointer update: on every transfer in round-robin mode, ptr <= (k==NCH-1) ? 0 : k+1.
  - ptr holds in manual mode and does not update on manual-mode transfers.
- Mode switch: takes effect in the same cycle mode changes; combinational choice. ptr is retained across a switch.
- Simultaneous consume and load: permitted in the same cycle. The new word replaces the old with no bubble.
- Reset mid-operation: rst wins over any transfer in that cycle. A pending output word is discarded, with no handshake on either side.
- Non-power-of-two NCH: pointer wrap uses an explicit compare with NCH-1, not modulo 2^SELW.

Test Plan:
1. Reset: assert rst with in_valid=4'b1111 and out_ready=1 -> in_ready=0 and out_valid=0. After release, the first grant goes to ch0.
2. Manual mode, sel=2, in_data ch2=8'hA5, in_valid=4'b0100, out_ready=1 -> in_ready=4'b0100. Next cycle out_data=8'hA5, out_ch=2, out_valid=1. sel=3 with in_valid=4'b0100 -> no grant, out_valid drops to 0.
3. Round-robin, all four channels valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0,1 on consecutive cycles with no bubbles.
4. Round-robin skip: ptr=1, in_valid=4'b1001 -> grant ch3, then ptr=0. Next grant ch0, then ptr=1.
5. Backpressure: out_valid=1, out_data=8'h3C, out_ready=0 for 3 cycles while inputs are valid -> out_data stays 8'h3C and in_ready=0. Raising out_ready gives consume and load in the same cycle, with new data next cycle.
6. NCH=3 build: all three channels valid, round-robin -> out_ch sequence 0,1,2,0 (wraps at 2, never 3). Assert rst mid-stream -> out_valid=0 next cycle, ptr=0.
